elevator_request_latch: RTL

- Parametrised successor to the elevator button-request block.
- Synchronises and debounces the in-car, hall-up and hall-down button vectors, then latches each request until it is serviced.
- Clears a request when the car stops at a floor with the doors open. Also drives floor-relative summary flags for the elevator controller FSM.
- Sits between the raw button pins and the car scheduling controller.

---
 rtl/elevator_request_latch_if.sv | 32 +++
 rtl/elevator_request_latch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/elevator_request_latch_if.sv
// Button, floor and request bundle between the raw button pins, the request latch and the car controller.
// master drives buttons and car state; slave returns latched requests and summary flags.
interface elevator_request_latch_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    logic [FLOORS-1:0]  btn_num_in;
    logic [FLOORS-1:0]  btn_up_out;
    logic [FLOORS-1:0]  btn_down_out;
    logic [FLOOR_W-1:0] cur_floor;
    logic               clear_en;
    logic               dir_up;
    logic [FLOORS-1:0]  active_in_levels;
    logic [FLOORS-1:0]  active_out_up_levels;
    logic [FLOORS-1:0]  active_out_down_levels;
    logic               req_above;
    logic               req_below;
    logic               req_here;
    logic               any_req;

    modport master (
        output btn_num_in, btn_up_out, btn_down_out, cur_floor, clear_en, dir_up,
        input  active_in_levels, active_out_up_levels, active_out_down_levels,
        input  req_above, req_below, req_here, any_req
    );

    modport slave (
        input  btn_num_in, btn_up_out, btn_down_out, cur_floor, clear_en, dir_up,
        output active_in_levels, active_out_up_levels, active_out_down_levels,
        output req_above, req_below, req_here, any_req
    );
endinterface

// File: rtl/elevator_request_latch.sv
// Synchronises and debounces elevator buttons, latches requests until a door-open stop clears them.
// Press-to-request latency DEBOUNCE_CYCLES+3 edges, clear next edge; no backpressure, requests held until serviced.
module elevator_request_latch #(
    parameter int FLOORS          = 8,
    parameter int FLOOR_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    elevator_request_latch_if.slave bus
);
    localparam int                NBITS      = 3 * FLOORS;
    localparam logic [CNT_W-1:0]  DB_MAX     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [FLOORS-1:0] UP_VALID   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [NBITS-1:0]            w_raw;
    logic [NBITS-1:0]            r_s1;
    logic [NBITS-1:0]            r_s2;
    logic [NBITS-1:0][CNT_W-1:0] r_cnt;
    logic [NBITS-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NBITS-1:0]            r_lvl;
    logic [NBITS-1:0]            r_lvl_d;
    logic [NBITS-1:0]            w_lvl_nxt;
    logic [NBITS-1:0]            w_rise;

    logic [FLOOR_W-1:0]          w_floor;
    logic                        w_clr_ok;
    logic [FLOORS-1:0]           w_clr_sel;
    logic [FLOORS-1:0]           w_clr_in;
    logic [FLOORS-1:0]           w_clr_up;
    logic [FLOORS-1:0]           w_clr_dn;
    logic [FLOORS-1:0]           w_set_in;
    logic [FLOORS-1:0]           w_set_up;
    logic [FLOORS-1:0]           w_set_dn;

    logic [FLOORS-1:0]           r_act_in;
    logic [FLOORS-1:0]           r_act_up;
    logic [FLOORS-1:0]           r_act_dn;
    logic [FLOORS-1:0]           w_mask;
    logic                        w_above;
    logic                        w_below;
    logic                        w_here;

    assign w_raw   = {bus.btn_down_out, bus.btn_up_out, bus.btn_num_in};
    assign w_floor = bus.cur_floor;

    // Counter saturates at DB_MAX; the level is simply "counter sits at DB_MAX".
    always_comb begin
        w_cnt_nxt = '0;
        w_lvl_nxt = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (r_s2[i]) begin
                w_cnt_nxt[i] = (r_cnt[i] < DB_MAX) ? r_cnt[i] + CNT_W'(1) : r_cnt[i];
            end
            w_lvl_nxt[i] = (w_cnt_nxt[i] == DB_MAX);
        end
    end

    assign w_rise   = r_lvl & ~r_lvl_d;
    assign w_set_in = w_rise[FLOORS-1:0];
    assign w_set_up = w_rise[2*FLOORS-1:FLOORS] & UP_VALID;
    assign w_set_dn = w_rise[3*FLOORS-1:2*FLOORS] & DOWN_VALID;

    // The opposite-direction hall call survives the stop; the car will return for it.
    assign w_clr_ok  = bus.clear_en && (int'(w_floor) < FLOORS);
    assign w_clr_sel = w_clr_ok ? (FLOORS'(1) << w_floor) : '0;
    assign w_clr_in  = w_clr_sel;
    assign w_clr_up  = bus.dir_up ? w_clr_sel : '0;
    assign w_clr_dn  = bus.dir_up ? '0 : w_clr_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_cnt    <= '0;
            r_lvl    <= '0;
            r_lvl_d  <= '0;
            r_act_in <= '0;
            r_act_up <= '0;
            r_act_dn <= '0;
        end else begin
            r_s1     <= w_raw;
            r_s2     <= r_s1;
            r_cnt    <= w_cnt_nxt;
            r_lvl    <= w_lvl_nxt;
            r_lvl_d  <= r_lvl;
            // Clear dominates a coincident set: the stop in progress satisfies it.
            r_act_in <= (r_act_in | w_set_in) & ~w_clr_in;
            r_act_up <= (r_act_up | w_set_up) & ~w_clr_up;
            r_act_dn <= (r_act_dn | w_set_dn) & ~w_clr_dn;
        end
    end

    // An out-of-range floor lands every bit in the "below" bucket naturally.
    always_comb begin
        w_mask  = r_act_in | r_act_up | r_act_dn;
        w_above = 1'b0;
        w_below = 1'b0;
        w_here  = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(w_floor)) begin
                w_above = w_above | w_mask[i];
            end else if (i < int'(w_floor)) begin
                w_below = w_below | w_mask[i];
            end else begin
                w_here = w_here | w_mask[i];
            end
        end
    end

    assign bus.active_in_levels       = r_act_in;
    assign bus.active_out_up_levels   = r_act_up;
    assign bus.active_out_down_levels = r_act_dn;
    assign bus.req_above              = w_above;
    assign bus.req_below              = w_below;
    assign bus.req_here               = w_here;
    assign bus.any_req                = |w_mask;
endmodule
